nbody_pair_scheduler: RTL
=========================

Name: nbody_pair_scheduler

Overview:
- Sequences the 256-body input buffer for the force stage after the buffer reports FULL.
- Walks every ordered body pair (i, j) with i != j, reading X/Y/Mass one field per cycle through the buffer's indexed read port.
- Emits one pair record per valid/ready handshake to the downstream force pipeline.
- At the end of a sweep, pulses the buffer CLEAR so the next timestep can be streamed in.

Parameters:
- N, 256, number of bodies; must be at least 2.
- IDX_BITS, $clog2(N), body index width.

Ports:
- CLK_IN  input  1  single clock, rising edge.
- RESET_IN  input  1  synchronous, active-low reset.
- START  input  1  one-cycle request to begin a sweep.
- ABORT  input  1  cancels the sweep and returns to IDLE.
- BUF_FULL  input  1  buffer FULL flag.
- BUF_CLEAR  output  1  one-cycle pulse to buffer CLEAR.
- RD_IDX  output  IDX_BITS  buffer read index.
- RD_SEL  output  2  buffer field select: 0 = X, 1 = Y, 2 = Mass, 3 = idle (buffer returns 0).
- BUF_DATA  input  16  buffer DATA_OUT (combinational read).
- M_VALID  output  1  pair record valid.
- M_READY  input  1  downstream ready.
- I_IDX, J_IDX  output  IDX_BITS each  pair indices.
- XI, YI, MI, XJ, YJ, MJ  output  16 each  body fields.
- ROW_LAST  output  1  marks the last pair of row i.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (RESET_IN = 0 at a clock edge):
  - State goes to IDLE; counters i, j and phase clear.
  - All outputs are 0, except RD_SEL = 3.
  - Reset overrides every other input, including mid-sweep; no DONE and no BUF_CLEAR are produced.
- States: IDLE, LOAD_I, LOAD_J, EMIT, FIN.
- Buffer reads:
  - RD_IDX and RD_SEL are combinational decodes of the state, phase and index registers.
  - BUF_DATA is captured at the clock edge that ends the same cycle.
  - RD_SEL = 3 and RD_IDX = 0 in IDLE, EMIT and FIN.
- IDLE:
  - START && BUF_FULL: set i = 0, phase = 0, go to LOAD_I.
  - START while BUF_FULL = 0 is ignored; no state is retained.
- LOAD_I (3 cycles):
  - Phase 0/1/2 drives RD_IDX = i and RD_SEL = phase, latching XI/YI/MI respectively.
  - After phase 2: j = (i == 0) ? 1 : 0, phase = 0, go to LOAD_J.
- LOAD_J (3 cycles): same as LOAD_I with RD_IDX = j, latching XJ/YJ/MJ. After phase 2, go to EMIT.
- EMIT:
  - M_VALID = 1. All record outputs stay stable until M_VALID && M_READY.
  - ROW_LAST = 1 when the next j would exceed N-1.
  - On accept, compute nj = j + 1, then nj = nj + 1 if nj == i.
  - If nj <= N-1: j = nj, go to LOAD_J.
  - Else if i == N-1: go to FIN.
  - Else: i = i + 1, go to LOAD_I.
  - The increment uses IDX_BITS+1 bits so that i = N-1, j = N-2 cannot wrap.
- FIN: DONE = 1 and BUF_CLEAR = 1 for exactly one cycle, then go to IDLE.
- M_VALID drops the cycle after accept and never reasserts until the next EMIT.
- ABORT:
  - In any non-IDLE state, go to IDLE at the next edge.
  - M_VALID deasserts without a handshake; no DONE, no BUF_CLEAR.
  - ABORT has priority over an accept in the same cycle; the accepted pair is dropped.
- START while BUSY is ignored.
- Timing:
  - START is sampled at edge t. LOAD_I spans cycles t+1..t+3, LOAD_J spans t+4..t+6, and the first M_VALID is at t+7.
  - Steady state with M_READY = 1: 4 cycles per pair; a row change adds 3 cycles.
  - Per sweep: N(N-1) pairs; ROW_LAST asserts N times; one DONE.
- BUF_FULL is sampled only in IDLE. The buffer contents must remain stable during the sweep, which holds because the buffer deasserts S_READY while full.

Test Plan:
- Fill (N = 4): X = 0x100 + i, Y = 0x200 + i, M = 0x300 + i, then START.
  - Required: 12 pairs in order (0,1),(0,2),(0,3),(1,0),(1,2),(1,3),(2,0),(2,1),(2,3),(3,0),(3,1),(3,2), with matching field values.
  - ROW_LAST on j = 3, 3, 3, 2.
  - First M_VALID 7 cycles after START.
  - DONE and BUF_CLEAR single-cycle pulses one cycle after the last accept.
- START with BUF_FULL = 0: BUSY stays 0, RD_SEL stays 3, no M_VALID.
- Random M_READY backpressure (N = 4):
  - Record outputs stable while M_VALID && !M_READY.
  - Still exactly 12 pairs, no duplicates, order unchanged.
- ABORT asserted during the 5th EMIT with M_READY = 1:
  - Next cycle IDLE, M_VALID = 0, no DONE or BUF_CLEAR.
  - A new START restarts at (0,1).
- RESET_IN = 0 in LOAD_J of pair (2,1):
  - All outputs return to reset values at the next edge.
  - After release, a sweep runs cleanly from (0,1).
- N = 256 full sweep with M_READY = 1:
  - 65280 pairs; last pair is (255,254) with ROW_LAST = 1.
  - The index counter does not wrap; DONE count = 1.

Source files
------------

// File: rtl/nbody_pair_scheduler.sv
// Pair scheduler for the N-body force stage: walks every ordered pair (i, j), i != j,
// loading body fields from the input buffer one per cycle and handing records downstream.
module nbody_pair_scheduler #(
  parameter int N        = 256,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                START,
  input  logic                ABORT,
  input  logic                BUF_FULL,
  output logic                BUF_CLEAR,
  output logic [IDX_BITS-1:0] RD_IDX,
  output logic [1:0]          RD_SEL,
  input  logic [15:0]         BUF_DATA,
  output logic                M_VALID,
  input  logic                M_READY,
  output logic [IDX_BITS-1:0] I_IDX,
  output logic [IDX_BITS-1:0] J_IDX,
  output logic [15:0]         XI,
  output logic [15:0]         YI,
  output logic [15:0]         MI,
  output logic [15:0]         XJ,
  output logic [15:0]         YJ,
  output logic [15:0]         MJ,
  output logic                ROW_LAST,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_J,
    S_EMIT,
    S_FIN
  } state_t;

  localparam logic [IDX_BITS:0] LAST_IDX = (IDX_BITS+1)'(N - 1);
  localparam logic [1:0]        SEL_IDLE = 2'd3;

  state_t              state, state_d;
  logic [IDX_BITS-1:0] i_q, i_d;
  logic [IDX_BITS-1:0] j_q, j_d;
  logic [1:0]          phase_q, phase_d;

  // One extra bit so that stepping past j = N-1 (or skipping i at the top) cannot wrap.
  logic [IDX_BITS:0]   nj_inc, nj;
  logic                accept;
  logic                loading;

  always_comb begin
    nj_inc = {1'b0, j_q} + (IDX_BITS+1)'(1);
    nj     = (nj_inc == {1'b0, i_q}) ? nj_inc + (IDX_BITS+1)'(1) : nj_inc;
  end

  assign accept   = (state == S_EMIT) && M_READY;
  assign loading  = (state == S_LOAD_I) || (state == S_LOAD_J);

  assign M_VALID   = (state == S_EMIT);
  assign ROW_LAST  = (state == S_EMIT) && (nj > LAST_IDX);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_FIN);
  assign BUF_CLEAR = (state == S_FIN);
  assign I_IDX     = i_q;
  assign J_IDX     = j_q;

  always_comb begin
    RD_SEL = loading ? phase_q : SEL_IDLE;
    unique case (state)
      S_LOAD_I: RD_IDX = i_q;
      S_LOAD_J: RD_IDX = j_q;
      default:  RD_IDX = '0;
    endcase
  end

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    i_d     = i_q;
    j_d     = j_q;
    phase_d = phase_q;

    if (state != S_IDLE && ABORT) begin
      state_d = S_IDLE;
      phase_d = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START && BUF_FULL) begin
            i_d     = '0;
            phase_d = '0;
            state_d = S_LOAD_I;
          end
        end
        S_LOAD_I: begin
          if (phase_q == 2'd2) begin
            j_d     = (i_q == '0) ? IDX_BITS'(1) : '0;
            phase_d = '0;
            state_d = S_LOAD_J;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        S_LOAD_J: begin
          if (phase_q == 2'd2) begin
            phase_d = '0;
            state_d = S_EMIT;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        S_EMIT: begin
          if (accept) begin
            if (nj <= LAST_IDX) begin
              j_d     = nj[IDX_BITS-1:0];
              state_d = S_LOAD_J;
            end else if ({1'b0, i_q} == LAST_IDX) begin
              state_d = S_FIN;
            end else begin
              i_d     = i_q + IDX_BITS'(1);
              state_d = S_LOAD_I;
            end
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      state   <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      phase_q <= '0;
    end else begin
      state   <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      phase_q <= phase_d;
    end
  end

  // NOTE: the field registers drive ports directly, so they are reset to keep outputs at 0.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      XI <= '0;
      YI <= '0;
      MI <= '0;
      XJ <= '0;
      YJ <= '0;
      MJ <= '0;
    end else if (state == S_LOAD_I) begin
      unique case (phase_q)
        2'd0:    XI <= BUF_DATA;
        2'd1:    YI <= BUF_DATA;
        default: MI <= BUF_DATA;
      endcase
    end else if (state == S_LOAD_J) begin
      unique case (phase_q)
        2'd0:    XJ <= BUF_DATA;
        2'd1:    YJ <= BUF_DATA;
        default: MJ <= BUF_DATA;
      endcase
    end
  end

endmodule
